// File: rtl/occ_defs.sv
// Shared definitions for the Occ table requester: base codes, ROM word lane
// layout, the index -1 address and the reader FSM state encoding.
package occ_defs;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  // k = 0 wraps to this address; the ROM answers it with an all-zero word.
  localparam logic [7:0] OCC_NEG1_ADDR = 8'hff;

  localparam logic [4:0] LANE_A_LSB = 5'd0;
  localparam logic [4:0] LANE_C_LSB = 5'd8;
  localparam logic [4:0] LANE_G_LSB = 5'd16;
  localparam logic [4:0] LANE_T_LSB = 5'd24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD_K = 2'd1,
    ST_RD_L = 2'd2,
    ST_DONE = 2'd3
  } occ_state_e;

  function automatic logic [4:0] lane_lsb(input logic [1:0] base);
    logic [4:0] lsb;
    case (base)
      BASE_A:  lsb = LANE_A_LSB;
      BASE_C:  lsb = LANE_C_LSB;
      BASE_G:  lsb = LANE_G_LSB;
      BASE_T:  lsb = LANE_T_LSB;
      default: lsb = LANE_A_LSB;
    endcase
    return lsb;
  endfunction

endpackage

// File: rtl/occ_byte_sel.sv
// Combinational lane mux: picks the count byte for one nucleotide out of a
// 32-bit Occ ROM word.
module occ_byte_sel
  import occ_defs::*;
#(
  parameter int CNT_W = 8
) (
  input  logic [31:0]      word,
  input  logic [1:0]       base,
  output logic [CNT_W-1:0] cnt
);

  // Lane select keyed by the nucleotide code.
  always_comb begin
    cnt = word[lane_lsb(base) +: CNT_W];
  end

endmodule

// File: rtl/occ_reader.sv
// Requester-side Occ lookup controller: reads Occ(base, k-1) and Occ(base, l)
// from the ROM in two sequential accesses and returns them with valid/ready.
module occ_reader
  import occ_defs::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_base,
  input  logic [ADDR_W-1:0] req_k,
  input  logic [ADDR_W-1:0] req_l,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              rom_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [CNT_W-1:0]  rsp_occ_k,
  output logic [CNT_W-1:0]  rsp_occ_l,
  output logic              rsp_empty
);

  occ_state_e        state_r;
  occ_state_e        state_nx;
  logic [1:0]        base_r;
  logic [ADDR_W-1:0] l_r;
  logic [CNT_W-1:0]  occ_k_r;
  logic [CNT_W-1:0]  sel_cnt;
  logic              load_req;
  logic              cap_k;
  logic              cap_l;
  logic              rom_ce_nx;
  logic [ADDR_W-1:0] rom_addr_nx;

  occ_byte_sel #(.CNT_W(CNT_W)) u_byte_sel (
    .word (rom_data),
    .base (base_r),
    .cnt  (sel_cnt)
  );

  assign req_ready = (state_r == ST_IDLE) && !rst;

  // Next-state decode; ROM pins are computed for the next state so they leave a register.
  always_comb begin
    state_nx    = state_r;
    load_req    = 1'b0;
    cap_k       = 1'b0;
    cap_l       = 1'b0;
    rom_ce_nx   = 1'b0;
    rom_addr_nx = {ADDR_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          load_req    = 1'b1;
          state_nx    = ST_RD_K;
          rom_ce_nx   = 1'b1;
          rom_addr_nx = req_k - ADDR_W'(1);
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_RD_K: begin
        rom_ce_nx = 1'b1;
        if (rom_valid) begin
          cap_k       = 1'b1;
          state_nx    = ST_RD_L;
          rom_addr_nx = l_r;
        end else begin
          rom_addr_nx = rom_addr;
        end
      end
      ST_RD_L: begin
        if (rom_valid) begin
          cap_l    = 1'b1;
          state_nx = ST_DONE;
        end else begin
          rom_ce_nx   = 1'b1;
          rom_addr_nx = rom_addr;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_DONE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State, request latches and response registers; responses persist after the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      base_r    <= 2'd0;
      l_r       <= {ADDR_W{1'b0}};
      occ_k_r   <= {CNT_W{1'b0}};
      rom_ce    <= 1'b0;
      rom_addr  <= {ADDR_W{1'b0}};
      rsp_valid <= 1'b0;
      rsp_occ_k <= {CNT_W{1'b0}};
      rsp_occ_l <= {CNT_W{1'b0}};
      rsp_empty <= 1'b0;
    end else begin
      state_r   <= state_nx;
      rom_ce    <= rom_ce_nx;
      rom_addr  <= rom_addr_nx;
      rsp_valid <= (state_nx == ST_DONE);
      if (load_req) begin
        base_r <= req_base;
        l_r    <= req_l;
      end
      if (cap_k) begin
        occ_k_r <= sel_cnt;
      end
      if (cap_l) begin
        rsp_occ_k <= occ_k_r;
        rsp_occ_l <= sel_cnt;
        rsp_empty <= (occ_k_r >= sel_cnt);
      end
    end
  end

endmodule

// File: tb/tb_occ_reader.sv
// Directed self-checking bench for occ_reader with a behavioural Occ ROM.
module tb_occ_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_base = 2'd0;
  logic [7:0]  req_k = 8'd0;
  logic [7:0]  req_l = 8'd0;
  logic        rom_ce;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        rom_valid;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_occ_k;
  logic [7:0]  rsp_occ_l;
  logic        rsp_empty;
  logic        stall = 1'b0;
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_data  = rom_ce ? mem[rom_addr] : 32'h0;
  assign rom_valid = rom_ce & ~stall;

  occ_reader #(.ADDR_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_base  (req_base),
    .req_k     (req_k),
    .req_l     (req_l),
    .rom_ce    (rom_ce),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rom_valid (rom_valid),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_occ_k (rsp_occ_k),
    .rsp_occ_l (rsp_occ_l),
    .rsp_empty (rsp_empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one request at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [1:0] b, input logic [7:0] k, input logic [7:0] l);
    req_valid = 1'b1;
    req_base  = b;
    req_k     = k;
    req_l     = l;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'h05060708;
    mem[8'h09] = 32'h0B0C0D0E;
    mem[8'h03] = 32'h02000000;
    mem[8'h10] = 32'h00000004;
    mem[8'h20] = 32'h00000004;
    mem[8'h30] = 32'h00030000;
    mem[8'h40] = 32'h00090000;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rom_ce", rom_ce, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_occ_k", rsp_occ_k, 0);
    check("rst_occ_l", rsp_occ_l, 0);
    check("rst_empty", rsp_empty, 0);
    rst = 1'b0;
    #1;
    check("idle_req_ready", req_ready, 1);
    @(negedge clk);
    check("idle_rom_ce", rom_ce, 0);

    // base=c, k=5, l=9
    send(2'd1, 8'd5, 8'd9);
    check("t1_ce_k", rom_ce, 1);
    check("t1_addr_k", rom_addr, 8'h04);
    check("t1_busy_ready", req_ready, 0);
    check("t1_valid_early0", rsp_valid, 0);
    @(negedge clk);
    check("t1_addr_l", rom_addr, 8'h09);
    check("t1_valid_early1", rsp_valid, 0);
    @(negedge clk);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_occ_k", rsp_occ_k, 8'h07);
    check("t1_occ_l", rsp_occ_l, 8'h0D);
    check("t1_empty", rsp_empty, 0);
    check("t1_ce_off", rom_ce, 0);
    check("t1_addr_off", rom_addr, 0);
    handshake();
    check("t1_post_valid", rsp_valid, 0);
    check("t1_post_ready", req_ready, 1);
    check("t1_post_hold_k", rsp_occ_k, 8'h07);
    check("t1_post_hold_l", rsp_occ_l, 8'h0D);

    // base=t, k=0 reads index -1
    send(2'd3, 8'd0, 8'h03);
    check("t2_addr_neg1", rom_addr, 8'hff);
    @(negedge clk);
    check("t2_addr_l", rom_addr, 8'h03);
    @(negedge clk);
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_occ_k", rsp_occ_k, 8'h00);
    check("t2_occ_l", rsp_occ_l, 8'h02);
    check("t2_empty", rsp_empty, 0);
    handshake();

    // equal counts -> empty
    send(2'd0, 8'h11, 8'h20);
    check("t3_addr_k", rom_addr, 8'h10);
    repeat (2) @(negedge clk);
    check("t3_rsp_valid", rsp_valid, 1);
    check("t3_occ_k", rsp_occ_k, 8'h04);
    check("t3_occ_l", rsp_occ_l, 8'h04);
    check("t3_empty", rsp_empty, 1);
    handshake();

    // held response while request inputs toggle
    send(2'd2, 8'd5, 8'd9);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req_valid = i[0];
      req_base  = i[1:0];
      req_k     = 8'h40 + 8'(i);
      req_l     = 8'h80 - 8'(i);
      @(negedge clk);
      check("t4_hold_valid", rsp_valid, 1);
      check("t4_hold_occ_k", rsp_occ_k, 8'h06);
      check("t4_hold_occ_l", rsp_occ_l, 8'h0C);
      check("t4_hold_empty", rsp_empty, 0);
      check("t4_hold_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    handshake();
    check("t4_idle_ready", req_ready, 1);
    check("t4_idle_valid", rsp_valid, 0);

    // ROM stalls two cycles during the l read
    send(2'd2, 8'h31, 8'h40);
    check("t5_accept_ce", rom_ce, 1);
    check("t5_addr_k", rom_addr, 8'h30);
    @(negedge clk);
    check("t5_addr_l", rom_addr, 8'h40);
    stall = 1'b1;
    @(negedge clk);
    check("t5_stall1_addr", rom_addr, 8'h40);
    check("t5_stall1_valid", rsp_valid, 0);
    @(negedge clk);
    check("t5_stall2_addr", rom_addr, 8'h40);
    check("t5_stall2_valid", rsp_valid, 0);
    stall = 1'b0;
    @(negedge clk);
    check("t5_rsp_valid", rsp_valid, 1);
    check("t5_occ_k", rsp_occ_k, 8'h03);
    check("t5_occ_l", rsp_occ_l, 8'h09);
    check("t5_empty", rsp_empty, 0);
    handshake();

    // reset during RD_K drops the request
    send(2'd1, 8'd5, 8'd9);
    check("t6_in_rdk", rom_ce, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_ce", rom_ce, 0);
    check("t6_rst_addr", rom_addr, 0);
    check("t6_rst_valid", rsp_valid, 0);
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_occ_k", rsp_occ_k, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_no_rsp", rsp_valid, 0);
      check("t6_idle_ready", req_ready, 1);
      check("t6_idle_ce", rom_ce, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
